// File: rtl/dis_display_driver.sv
// -----------------------------------------------------------------------------
// dis_display_driver
//
// Purpose:
//   Shows a 16-bit value on a 6-position multiplexed 7-segment panel.
//   A sequential shift-add-3 (double-dabble) engine converts the value to
//   five BCD digits. Each finished result is copied into a display latch,
//   so the panel never shows a half-converted number. A refresh counter
//   steps through the digit positions.
//
// Ports:
//   CLK   in   1   system clock, rising edge
//   RST   in   1   synchronous reset, active high
//   VAL   in  16   value to display
//   SEG   out  7   segments {g,f,e,d,c,b,a}, active low
//   DP    out  1   decimal point, active low, always off
//   AN    out  6   anodes, active low; AN[0] ones ... AN[4] ten-thousands,
//                  AN[5] sign position
//   BUSY  out  1   conversion in progress (SHIFT or LOAD)
//
// Parameters:
//   REFRESH_CNT    clock cycles per digit slot (2 .. 2**20)
//   BLANK_LEADING  1 = blank leading zeros, 0 = show all five digits
//
// Build option:
//   DIS_SIGNED_EN  when defined, VAL is two's complement. The magnitude is
//                  converted, and position 5 shows a minus sign for
//                  negative values. When undefined, no sign logic exists.
//
// States:
//   state   | meaning
//   S_IDLE  | capture VAL, clear accumulator
//   S_SHIFT | 16 add-3/shift iterations, one per cycle
//   S_LOAD  | copy accumulator into display latch
// -----------------------------------------------------------------------------
module dis_display_driver #(
    parameter int unsigned REFRESH_CNT   = 100000,
    parameter int unsigned BLANK_LEADING = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] VAL,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic [5:0]  AN,
    output logic        BUSY
);

    localparam int RW = $clog2(REFRESH_CNT);
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LOAD
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] bin_sr;
    logic [19:0] bcd_acc;
    logic [15:0] adj;
    logic [4:0]  iter;
    logic [19:0] disp_bcd;

`ifdef DIS_SIGNED_EN
    logic        sign_cap;
    logic        disp_sign;
`endif

    logic [RW-1:0] ref_cnt;
    logic [2:0]    dig_idx;
    logic [3:0]    nib;
    logic [4:0]    nz;
    logic [6:0]    seg_sel;
    logic [5:0]    an_sel;

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_SHIFT;
            S_SHIFT: if (iter == 5'd15) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign BUSY = (state != S_IDLE);
    assign DP   = 1'b1;

    // ----------------------------------------------------- double dabble
    // Only nibbles 0..3 need the add-3 step: the ten-thousands nibble is at
    // most 3 before the final shift (65535 -> 6), so it can never reach 5.
    always_comb begin
        adj = bcd_acc[15:0];
        for (int k = 0; k < 4; k++) begin
            if (bcd_acc[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bin_sr    <= '0;
            bcd_acc   <= '0;
            iter      <= '0;
            disp_bcd  <= '0;
`ifdef DIS_SIGNED_EN
            sign_cap  <= 1'b0;
            disp_sign <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
`ifdef DIS_SIGNED_EN
                    if (VAL[15]) begin
                        bin_sr <= ~VAL + 16'd1;
                    end else begin
                        bin_sr <= VAL;
                    end
                    sign_cap <= VAL[15];
`else
                    bin_sr   <= VAL;
`endif
                    bcd_acc  <= '0;
                    iter     <= '0;
                end
                S_SHIFT: begin
                    bcd_acc <= {bcd_acc[18:16], adj, bin_sr[15]};
                    bin_sr  <= {bin_sr[14:0], 1'b0};
                    iter    <= iter + 5'd1;
                end
                S_LOAD: begin
                    disp_bcd  <= bcd_acc;
`ifdef DIS_SIGNED_EN
                    disp_sign <= sign_cap;
`endif
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------ display scan
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            nz[k] = (disp_bcd[4*k +: 4] != 4'd0);
        end
    end

    always_comb begin
        nib     = 4'd0;
        seg_sel = 7'h7F;
        an_sel  = 6'h3F;
        case (dig_idx)
            3'd0: nib = disp_bcd[3:0];
            3'd1: nib = disp_bcd[7:4];
            3'd2: nib = disp_bcd[11:8];
            3'd3: nib = disp_bcd[15:12];
            3'd4: nib = disp_bcd[19:16];
            default: nib = 4'd0;
        endcase
        if (dig_idx <= 3'd4) begin
            // A digit is a leading zero when it and every digit above it are 0;
            // the ones digit is never blanked so zero still reads "0".
            if ((BLANK_LEADING != 0) && (dig_idx != 3'd0) && ((nz >> dig_idx) == 5'd0)) begin
                seg_sel = 7'h7F;
                an_sel  = 6'h3F;
            end else begin
                seg_sel = seg_dec(nib);
                an_sel  = ~(6'd1 << dig_idx);
            end
        end else begin
`ifdef DIS_SIGNED_EN
            if (disp_sign) begin
                seg_sel = 7'b0111111;
                an_sel  = 6'b011111;
            end
`endif
        end
    end

    // SEG and AN are loaded on the same edge so they always describe one slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ref_cnt <= '0;
            dig_idx <= '0;
            SEG     <= 7'h7F;
            AN      <= 6'h3F;
        end else begin
            if (ref_cnt == REF_LAST) begin
                ref_cnt <= '0;
                dig_idx <= (dig_idx == 3'd5) ? 3'd0 : dig_idx + 3'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
            SEG <= seg_sel;
            AN  <= an_sel;
        end
    end

endmodule

// File: tb/tb_dis_display_driver.sv
// -----------------------------------------------------------------------------
// tb_dis_display_driver
//
// Purpose:
//   Self-checking bench for dis_display_driver. Two instances run side by
//   side with a short refresh period: one blanks leading zeros and one does
//   not. Expected segment patterns per position come from a decimal model
//   and are queued when a value is applied, then popped when the panel scan
//   is observed.
//
// Ports: none (top-level bench). Honours DIS_SIGNED_EN in its model.
// -----------------------------------------------------------------------------
module tb_dis_display_driver;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] VAL;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [5:0]  an_a, an_b;
    logic        busy_a, busy_b;

    int total = 0;
    int bad   = 0;

    logic [13:0] sb_q[$];

    dis_display_driver #(.REFRESH_CNT(4), .BLANK_LEADING(1)) u_dut (
        .CLK(CLK), .RST(RST), .VAL(VAL),
        .SEG(seg_a), .DP(dp_a), .AN(an_a), .BUSY(busy_a)
    );

    dis_display_driver #(.REFRESH_CNT(4), .BLANK_LEADING(0)) u_dut_nb (
        .CLK(CLK), .RST(RST), .VAL(VAL),
        .SEG(seg_b), .DP(dp_b), .AN(an_b), .BUSY(busy_b)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ model
    function automatic int mag_of(input logic [15:0] v);
        int m;
        m = int'(v);
`ifdef DIS_SIGNED_EN
        if (v[15]) m = 65536 - int'(v);
`endif
        return m;
    endfunction

    function automatic bit neg_of(input logic [15:0] v);
`ifdef DIS_SIGNED_EN
        return v[15];
`else
        return (v === 16'hxxxx);
`endif
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int pos, input bit bl);
        int m;
        int p10;
        m = mag_of(v);
        if (pos == 5) return neg_of(v) ? 7'b0111111 : 7'b1111111;
        p10 = 10 ** pos;
        if (bl && pos >= 1 && m < p10) return 7'b1111111;
        return seg_of((m / p10) % 10);
    endfunction

    function automatic logic [19:0] bcd_of(input logic [15:0] v);
        int m;
        logic [19:0] b;
        m = mag_of(v);
        b = '0;
        for (int k = 0; k < 5; k++) begin
            b[4*k +: 4] = 4'((m / (10 ** k)) % 10);
        end
        return b;
    endfunction

    // ------------------------------------------------------------ helpers
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] v);
        for (int p = 0; p < 6; p++) begin
            sb_q.push_back({exp_seg(v, p, 1'b1), exp_seg(v, p, 1'b0)});
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < 40) begin
            tick(1);
            n++;
        end
        if (busy_a !== 1'b0) begin
            total++;
            bad++;
            $error("FAIL idle_timeout observed=busy expected=idle");
        end
    endtask

    task automatic scan_check(input string tag);
        logic [6:0] obs_a[6];
        logic [6:0] obs_b[6];
        logic [13:0] e;
        bit an_ok;
        an_ok = 1'b1;
        for (int p = 0; p < 6; p++) begin
            obs_a[p] = 7'h7F;
            obs_b[p] = 7'h7F;
        end
        repeat (28) begin
            tick(1);
            if ($countones(~an_a) > 1 || $countones(~an_b) > 1) an_ok = 1'b0;
            for (int p = 0; p < 6; p++) begin
                if (!an_a[p]) obs_a[p] = seg_a;
                if (!an_b[p]) obs_b[p] = seg_b;
            end
        end
        chk({tag, "_an_onehot"}, 32'(an_ok), 32'd1);
        for (int p = 0; p < 6; p++) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s_queue observed=empty expected=entry", tag);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("%s_blank_pos%0d", tag, p), 32'(obs_a[p]), 32'(e[13:7]));
                chk($sformatf("%s_full_pos%0d", tag, p), 32'(obs_b[p]), 32'(e[6:0]));
            end
        end
    endtask

    task automatic run_value(input string tag, input logic [15:0] v);
        VAL = v;
        push_exp(v);
        tick(40);
        chk({tag, "_latch"}, 32'(u_dut.disp_bcd), 32'(bcd_of(v)));
        scan_check(tag);
    endtask

    task automatic refresh_check(input logic [15:0] v);
        logic [5:0] prev;
        logic [5:0] exp_an;
        bit found;
        int slot;
        found = 1'b0;
        prev  = an_a;
        for (int n = 0; n < 40 && !found; n++) begin
            tick(1);
            if (an_a == 6'b111110 && prev != 6'b111110) found = 1'b1;
            prev = an_a;
        end
        if (!found) begin
            total++;
            bad++;
            $error("FAIL refresh_align observed=none expected=slot0");
        end else begin
            for (int k = 0; k < 24; k++) begin
                slot = k / 4;
                if (slot < 5) exp_an = ~(6'd1 << slot);
                else exp_an = (exp_seg(v, 5, 1'b1) == 7'h7F) ? 6'h3F : 6'b011111;
                chk($sformatf("refresh_c%0d", k), 32'(an_a), 32'(exp_an));
                tick(1);
            end
        end
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        RST = 1'b1;
        VAL = 16'h1234;
        tick(3);
        chk("rst_seg",   32'(seg_a),  32'h7F);
        chk("rst_an",    32'(an_a),   32'h3F);
        chk("rst_dp",    32'(dp_a),   32'h1);
        chk("rst_busy",  32'(busy_a), 32'h0);
        chk("rst_seg_b", 32'(seg_b),  32'h7F);
        chk("rst_an_b",  32'(an_b),   32'h3F);
        chk("rst_dp_b",  32'(dp_b),   32'h1);
        chk("rst_busy_b",32'(busy_b), 32'h0);
        chk("rst_latch", 32'(u_dut.disp_bcd), 32'h0);

        RST = 1'b0;
        push_exp(16'h1234);
        tick(1);
        chk("busy_first_shift", 32'(busy_a), 32'h1);
        tick(16);
        chk("busy_load",        32'(busy_a), 32'h1);
        chk("latch_before_load",32'(u_dut.disp_bcd), 32'h0);
        tick(1);
        chk("busy_back_idle",   32'(busy_a), 32'h0);
        chk("latch_first",      32'(u_dut.disp_bcd), 32'(bcd_of(16'h1234)));
        tick(30);
        scan_check("v4660");

        run_value("vmax", 16'hFFFF);
        refresh_check(16'hFFFF);
        run_value("vzero", 16'h0000);
        run_value("v8000", 16'h8000);
        run_value("v7", 16'h0007);

        // mid-conversion change: 100 captured, 200 arrives during SHIFT
        wait_idle();
        VAL = 16'd100;
        tick(5);
        VAL = 16'd200;
        tick(12);
        chk("mid_t16", 32'(u_dut.disp_bcd), 32'(bcd_of(16'h0007)));
        tick(1);
        chk("mid_t17", 32'(u_dut.disp_bcd), 32'(bcd_of(16'd100)));
        tick(17);
        chk("mid_t34", 32'(u_dut.disp_bcd), 32'(bcd_of(16'd100)));
        tick(1);
        chk("mid_t35", 32'(u_dut.disp_bcd), 32'(bcd_of(16'd200)));

        // reset in the middle of a conversion
        wait_idle();
        tick(5);
        RST = 1'b1;
        tick(1);
        chk("rstmid_busy",  32'(busy_a), 32'h0);
        chk("rstmid_seg",   32'(seg_a),  32'h7F);
        chk("rstmid_an",    32'(an_a),   32'h3F);
        chk("rstmid_latch", 32'(u_dut.disp_bcd), 32'h0);
        RST = 1'b0;
        run_value("v200", 16'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
